irq_scheduler: RTL
==================

Name: irq_scheduler

Overview:
- Generates, queues and presents the two CPU interrupt lines: line 0 is the periodic timer tick, line 1 is keyboard key-press with typematic auto-repeat.
- Sits between kb_driver and the pipeline's irq_pins/irq_en interface in riscv_hardware.
- Replaces the ad-hoc timer and keyboard logic with pending latches, per-line acknowledge, overrun counting and a fixed priority.

Parameters:
- TIMER_PERIOD, 50000000, clk cycles between timer ticks (>=2).
- KB_DELAY, 25000000, cycles from first key event to first repeat (>=2).
- KB_REPEAT, 12500000, cycles between subsequent repeats (>=2).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  synchronous reset, active-high.
- irq_en  in  1  CPU global interrupt enable from pipeline.
- irq_ack  in  2  per-line acknowledge pulse from CPU/memory_map; bit i clears pending i.
- kb_ascii  in  8  current ASCII from kb_driver; 0 means no key held.
- irq_pins  out  2  registered interrupt request lines to pipeline.
- irq_id  out  1  highest-priority pending line (1 = keyboard, 0 = timer).
- kb_code  out  8  ASCII latched at last keyboard event.
- ovf_cnt  out  8  saturating count of events lost to an already-pending line.

Behaviour:
- Reset (synchronous, rst high at a clk edge) clears all outputs to 0, pending[1:0] to 0, timer count to 1 and keyboard FSM to KB_IDLE. Reset mid-repeat discards the repeat state and any pending events.
- Timer:
  - tcnt counts 1..TIMER_PERIOD.
  - On the cycle tcnt==TIMER_PERIOD: tcnt<=1 and a timer event fires. Events are therefore exactly TIMER_PERIOD cycles apart.
  - Timer runs regardless of irq_en.
- Keyboard FSM (kcnt counter, 32 bit):
  - KB_IDLE: if kb_ascii!=0, fire keyboard event, kb_code<=kb_ascii, kcnt<=1, go to KB_DELAY.
  - KB_DELAY: if kb_ascii==0, go to KB_IDLE (no event). Else if kb_ascii!=kb_code, fire event, latch new code, kcnt<=1, stay. Else if kcnt==KB_DELAY, fire event, kcnt<=1, go to KB_REPEAT. Else kcnt++.
  - KB_REPEAT: same release and change rules, where a change returns to KB_DELAY. When kcnt==KB_REPEAT, fire event and set kcnt<=1.
  - Release takes priority over change, and change takes priority over expiry.
- Pending:
  - A line's event sets pending[i]. irq_ack[i] clears it.
  - Event and ack on the same cycle: pending stays 1, so the event is not lost.
  - Event while pending[i] is already 1 and not acked that cycle: ovf_cnt++, saturating at 255. Two simultaneous overruns count +2, saturating.
- Outputs:
  - irq_pins <= pending & {2{irq_en}}, registered, giving 1-cycle latency from the pending set to the pin.
  - irq_en low masks the pins only; pending is retained and reappears one cycle after irq_en returns high.
  - irq_id is combinational from pending: 1 if pending[1], else 0. It is 0 when nothing is pending.
- Width rules: counters are 32-bit unsigned. Parameters must fit in 31 bits.

Optional Feature:
- Macro IRQ_SCHED_MASK_EN.
- When defined: adds input irq_mask [1:0]. A masked line still latches pending and counts overruns, but irq_pins is forced 0 for that line, and irq_id ignores masked lines.
- When undefined: the port is absent and behaviour is as above.

Decomposition:
- Package irq_sched_pkg holds:
  - IRQ_TIMER=0 and IRQ_KB=1 line indices.
  - Keyboard FSM state encoding: KB_IDLE, KB_DELAY, KB_REPEAT, one-hot 3 bit.
  - Counter width constant CNT_W=32.
- One sub-module, kb_typematic, holds the keyboard FSM and kcnt. It outputs a single-cycle kb_event and kb_code.
- Timer, pending, overrun and output logic stay in irq_scheduler.

Test Plan:
- TIMER_PERIOD=10, irq_en=1, no acks after reset release -> irq_pins[0] rises 1 cycle after the first tick and stays high; ovf_cnt reads 1, 2, 3 at later ticks spaced 10 cycles apart.
- KB_DELAY=5, KB_REPEAT=3, kb_ascii=0x61 held, CPU acks each event -> events at cycles t, t+5, t+8, t+11; kb_code=0x61; ovf_cnt=0.
- Key held, kb_ascii changes 0x61->0x62 in KB_REPEAT -> immediate event; kb_code=0x62; next repeat comes 5 cycles later (delay restarted).
- Timer event and irq_ack[0] in the same cycle -> pending[0] stays 1; irq_pins[0] stays high.
- irq_en=0 while a keyboard event fires -> irq_pins=00; raising irq_en -> irq_pins[1]=1 next cycle; irq_id=1 with both lines pending.
- rst pulse during KB_REPEAT with both lines pending -> all outputs 0 next cycle; key still held -> fresh event 1 cycle after rst deasserts.

Source files
------------

// File: rtl/irq_sched_pkg.sv
// irq_sched_pkg: shared line indices, keyboard FSM encoding and counter width
package irq_sched_pkg;
  localparam int IRQ_TIMER = 0;
  localparam int IRQ_KB = 1;
  localparam int CNT_W = 32;
  typedef enum logic [2:0] {
    KB_IDLE   = 3'b001,
    KB_DELAY  = 3'b010,
    KB_REPEAT = 3'b100
  } kb_state_t;
endpackage

// File: rtl/kb_typematic.sv
// kb_typematic: key-press detection with typematic delay/repeat, one-cycle kb_event
// Ports: clk, rst (sync, active-high), kb_ascii (0 = no key), kb_event (registered pulse),
// kb_code (ASCII latched at the last event).
module kb_typematic #(
  parameter int DELAY = 25000000,
  parameter int REPEAT = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_ascii,
  output logic       kb_event,
  output logic [7:0] kb_code
);
  import irq_sched_pkg::*;
  kb_state_t r_state;
  logic [CNT_W-1:0] r_kcnt;
  logic [CNT_W-1:0] w_lim;
  logic r_event;
  logic [7:0] r_code;
  assign w_lim = (r_state == KB_DELAY) ? CNT_W'(DELAY) : CNT_W'(REPEAT);
  // Release beats a code change, which beats counter expiry.
  always_ff @(posedge clk) begin
    r_event <= 1'b0;
    if (rst) begin
      r_state <= KB_IDLE;
      r_kcnt <= CNT_W'(1);
      r_code <= 8'd0;
    end else if (r_state == KB_IDLE) begin
      if (kb_ascii != 8'd0) begin
        r_event <= 1'b1;
        r_code <= kb_ascii;
        r_kcnt <= CNT_W'(1);
        r_state <= KB_DELAY;
      end
    end else if (kb_ascii == 8'd0) begin
      r_state <= KB_IDLE;
    end else if (kb_ascii != r_code) begin
      r_event <= 1'b1;
      r_code <= kb_ascii;
      r_kcnt <= CNT_W'(1);
      r_state <= KB_DELAY;
    end else if (r_kcnt == w_lim) begin
      r_event <= 1'b1;
      r_kcnt <= CNT_W'(1);
      r_state <= KB_REPEAT;
    end else begin
      r_kcnt <= r_kcnt + CNT_W'(1);
    end
  end
  assign kb_event = r_event;
  assign kb_code = r_code;
endmodule

// File: rtl/irq_scheduler.sv
// irq_scheduler: timer tick and keyboard interrupt generation, pending latches, priority, overrun count
// Ports: clk, rst (sync, active-high), irq_en (global enable), irq_ack[1:0] (per-line clear),
// kb_ascii (held key, 0 = none), irq_pins[1:0] (registered requests), irq_id (1 = keyboard pending),
// kb_code (last keyboard ASCII), ovf_cnt (saturating lost-event count).
// Optional macro IRQ_SCHED_MASK_EN adds irq_mask[1:0], gating pins and irq_id per line.
module irq_scheduler #(
  parameter int TIMER_PERIOD = 50000000,
  parameter int KB_DELAY = 25000000,
  parameter int KB_REPEAT = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       irq_en,
  input  logic [1:0] irq_ack,
`ifdef IRQ_SCHED_MASK_EN
  input  logic [1:0] irq_mask,
`endif
  input  logic [7:0] kb_ascii,
  output logic [1:0] irq_pins,
  output logic       irq_id,
  output logic [7:0] kb_code,
  output logic [7:0] ovf_cnt
);
  import irq_sched_pkg::*;
  logic [CNT_W-1:0] r_tcnt;
  logic [1:0] r_pend;
  logic [1:0] r_pins;
  logic [7:0] r_ovf;
  logic [1:0] w_mask;
  logic [1:0] w_ev;
  logic [1:0] w_lost;
  logic [8:0] w_sum;
  logic w_tev;
  logic w_kev;
`ifdef IRQ_SCHED_MASK_EN
  assign w_mask = irq_mask;
`else
  assign w_mask = 2'b00;
`endif
  kb_typematic #(.DELAY(KB_DELAY), .REPEAT(KB_REPEAT)) u_kb (
    .clk(clk),
    .rst(rst),
    .kb_ascii(kb_ascii),
    .kb_event(w_kev),
    .kb_code(kb_code)
  );
  assign w_tev = r_tcnt == CNT_W'(TIMER_PERIOD);
  assign w_ev[IRQ_TIMER] = w_tev;
  assign w_ev[IRQ_KB] = w_kev;
  // An event only counts as lost if the line is still pending and not being acked this cycle.
  assign w_lost = w_ev & r_pend & ~irq_ack;
  assign w_sum = {1'b0, r_ovf} + {8'd0, w_lost[0]} + {8'd0, w_lost[1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt <= CNT_W'(1);
      r_pend <= 2'b00;
      r_pins <= 2'b00;
      r_ovf <= 8'd0;
    end else begin
      r_tcnt <= w_tev ? CNT_W'(1) : r_tcnt + CNT_W'(1);
      r_pend <= (r_pend & ~irq_ack) | w_ev;
      r_pins <= r_pend & {2{irq_en}} & ~w_mask;
      r_ovf <= w_sum[8] ? 8'hff : w_sum[7:0];
    end
  end
  assign irq_pins = r_pins;
  assign irq_id = r_pend[IRQ_KB] & ~w_mask[IRQ_KB];
  assign ovf_cnt = r_ovf;
endmodule
